// File: rtl/uart_rx_fifo_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the UART receive path.
//   rx_entry_t       : one received character plus its error flags
//   rx_trig_e        : encoding of the FCR receive-trigger field
//   trig_level()     : trigger encoding -> occupancy threshold
//   RX_TIMEOUT_CHARS : idle character times before a receive timeout
// Optional feature macro used by the receive FIFO: UART_RX_TIMEOUT_EN.
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef struct packed {
        logic       brk;
        logic       ferr;
        logic       perr;
        logic [7:0] data;
    } rx_entry_t;

    typedef enum logic [1:0] {
        TRIG_1  = 2'b00,
        TRIG_4  = 2'b01,
        TRIG_8  = 2'b10,
        TRIG_14 = 2'b11
    } rx_trig_e;

    localparam int RX_TIMEOUT_CHARS = 4;

    // The thresholds are the 16550 values and do not scale with FIFO depth.
    function automatic int unsigned trig_level(rx_trig_e sel);
        int unsigned lvl;
        case (sel)
            TRIG_1:  lvl = 1;
            TRIG_4:  lvl = 4;
            TRIG_8:  lvl = 8;
            default: lvl = 14;
        endcase
        return lvl;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo_if
// Bundle of every non-clock signal of the receive FIFO.
//   Producer side : i_rx_data, i_rx_perr, i_rx_ferr, i_rx_brk, i_rx_valid
//   Consumer side : i_rd_en, i_lsr_rd, i_clr, i_trig_lvl
//   Status        : o_rd_data, o_data_ready, o_overrun, o_parity_err,
//                   o_framing_err, o_break, o_fifo_err, o_count, o_trig
//   DMA           : RXDRDYn (active low)
//   UART_RX_TIMEOUT_EN adds i_char_tick and o_timeout.
// Modports: master = surrounding logic driving the FIFO, slave = the FIFO.
// ---------------------------------------------------------------------------
interface uart_rx_fifo_if #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] i_rx_data;
    logic              i_rx_perr;
    logic              i_rx_ferr;
    logic              i_rx_brk;
    logic              i_rx_valid;
    logic              i_rd_en;
    logic              i_lsr_rd;
    logic              i_clr;
    logic [1:0]        i_trig_lvl;

    logic [DATA_W-1:0] o_rd_data;
    logic              o_data_ready;
    logic              o_overrun;
    logic              o_parity_err;
    logic              o_framing_err;
    logic              o_break;
    logic              o_fifo_err;
    logic [PTR_W:0]    o_count;
    logic              o_trig;
    logic              RXDRDYn;

`ifdef UART_RX_TIMEOUT_EN
    logic              i_char_tick;
    logic              o_timeout;
`endif

    modport master (
`ifdef UART_RX_TIMEOUT_EN
        output i_char_tick,
        input  o_timeout,
`endif
        output i_rx_data, i_rx_perr, i_rx_ferr, i_rx_brk, i_rx_valid,
        output i_rd_en, i_lsr_rd, i_clr, i_trig_lvl,
        input  o_rd_data, o_data_ready, o_overrun, o_parity_err,
        input  o_framing_err, o_break, o_fifo_err, o_count, o_trig, RXDRDYn
    );

    modport slave (
`ifdef UART_RX_TIMEOUT_EN
        input  i_char_tick,
        output o_timeout,
`endif
        input  i_rx_data, i_rx_perr, i_rx_ferr, i_rx_brk, i_rx_valid,
        input  i_rd_en, i_lsr_rd, i_clr, i_trig_lvl,
        output o_rd_data, o_data_ready, o_overrun, o_parity_err,
        output o_framing_err, o_break, o_fifo_err, o_count, o_trig, RXDRDYn
    );

endinterface

// File: rtl/uart_rx_fifo_core.sv
// ---------------------------------------------------------------------------
// uart_fifo_core
// Generic register-array FIFO, element type T, power-of-two DEPTH.
//   clk, rst         : clock, asynchronous active-high reset
//   push, pop, clr   : write request, read request, synchronous flush
//   wr_data, rd_data : write element, head element (fall-through, raw)
//   count            : occupancy, full / empty flags
//   push_ok, pop_ok  : the push / pop that actually takes effect this cycle
// A push into a full FIFO is accepted only when a pop frees a slot in the
// same cycle; a pop of an empty FIFO is ignored. clr wins over both.
// ---------------------------------------------------------------------------
module uart_fifo_core #(
    parameter type T     = logic [7:0],
    parameter int  DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       clr,
    input  T                           wr_data,
    output T                           rd_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic                       push_ok,
    output logic                       pop_ok
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

    T                 mem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign rd_data = mem[rptr];

    // Pointers wrap for free because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (clr) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push_ok) wptr <= wptr + 1'b1;
            if (pop_ok)  rptr <= rptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; unread slots are masked by the top.
    always_ff @(posedge clk) begin
        if (push_ok && !clr) mem[wptr] <= wr_data;
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
// UART receive buffer between uart_rx and the APB register file. Holds each
// character with its parity / framing / break flags and produces the LSR
// receive bits, the trigger flag and the DMA request RXDRDYn.
//   PCLK, PRESET : clock, asynchronous active-high reset
//   bus (slave)  : uart_rx_fifo_if, see that file for the signal list
// Optional feature macro: UART_RX_TIMEOUT_EN adds the character-time idle
// timeout (i_char_tick in, o_timeout out) which also requests DMA.
// ---------------------------------------------------------------------------
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8
) (
    input  logic          PCLK,
    input  logic          PRESET,
    uart_rx_fifo_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic              brk;
        logic              ferr;
        logic              perr;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t         wr_entry;
    entry_t         head_raw;
    logic [PTR_W:0] count;
    logic           full;
    logic           empty;
    logic           push_ok;
    logic           pop_ok;
    logic           overrun_q;
    logic           trig_q;
    logic [PTR_W:0] err_cnt;
    logic           push_err;
    logic           pop_err;
    logic           req_n;

    assign wr_entry.brk  = bus.i_rx_brk;
    assign wr_entry.ferr = bus.i_rx_ferr;
    assign wr_entry.perr = bus.i_rx_perr;
    assign wr_entry.data = bus.i_rx_data;

    uart_fifo_core #(
        .T     (entry_t),
        .DEPTH (DEPTH)
    ) u_core (
        .clk     (PCLK),
        .rst     (PRESET),
        .push    (bus.i_rx_valid),
        .pop     (bus.i_rd_en),
        .clr     (bus.i_clr),
        .wr_data (wr_entry),
        .rd_data (head_raw),
        .count   (count),
        .full    (full),
        .empty   (empty),
        .push_ok (push_ok),
        .pop_ok  (pop_ok)
    );

    // A dropped character sets the sticky overrun; setting beats the LSR read.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET)                                     overrun_q <= 1'b0;
        else if (bus.i_rx_valid && full && !bus.i_rd_en) overrun_q <= 1'b1;
        else if (bus.i_lsr_rd)                          overrun_q <= 1'b0;
    end

    // Number of stored entries carrying any error flag, for LSR[7].
    assign push_err = push_ok && (bus.i_rx_perr || bus.i_rx_ferr || bus.i_rx_brk);
    assign pop_err  = pop_ok && (head_raw.perr || head_raw.ferr || head_raw.brk);

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET)                    err_cnt <= '0;
        else if (bus.i_clr)            err_cnt <= '0;
        else if (push_err && !pop_err) err_cnt <= err_cnt + 1'b1;
        else if (pop_err && !push_err) err_cnt <= err_cnt - 1'b1;
    end

    // Trigger follows the registered occupancy, so it lags count by a cycle.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) trig_q <= 1'b0;
        else        trig_q <= (32'(count) >= trig_level(rx_trig_e'(bus.i_trig_lvl)));
    end

`ifdef UART_RX_TIMEOUT_EN
    logic [1:0] idle_cnt;
    logic       timeout_q;

    // Counts character times with data waiting and no FIFO traffic; the
    // RX_TIMEOUT_CHARS-th idle tick raises the timeout until traffic resumes.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            idle_cnt  <= '0;
            timeout_q <= 1'b0;
        end else if (bus.i_rx_valid || bus.i_rd_en || bus.i_clr || empty) begin
            idle_cnt  <= '0;
            timeout_q <= 1'b0;
        end else if (bus.i_char_tick) begin
            if (idle_cnt == 2'(RX_TIMEOUT_CHARS - 1)) timeout_q <= 1'b1;
            else                                      idle_cnt  <= idle_cnt + 1'b1;
        end
    end

    assign bus.o_timeout = timeout_q;
    assign req_n         = ~(trig_q | timeout_q);
`else
    assign req_n         = ~trig_q;
`endif

    assign bus.o_rd_data     = empty ? '0 : head_raw.data;
    assign bus.o_parity_err  = !empty && head_raw.perr;
    assign bus.o_framing_err = !empty && head_raw.ferr;
    assign bus.o_break       = !empty && head_raw.brk;
    assign bus.o_data_ready  = !empty;
    assign bus.o_overrun     = overrun_q;
    assign bus.o_fifo_err    = (err_cnt != '0);
    assign bus.o_count       = count;
    assign bus.o_trig        = trig_q;
    assign bus.RXDRDYn       = req_n;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_fifo
// Bench for uart_rx_fifo. The reference model is a queue of expected entries
// plus an occupancy count; a negedge monitor pops the queue whenever a read
// is presented and compares the head the DUT shows. Status outputs are
// compared after every clock. Honours UART_RX_TIMEOUT_EN.
// ---------------------------------------------------------------------------
module tb_uart_rx_fifo;
    import uart_pkg::*;

    localparam int DEPTH = 16;

    logic PCLK   = 1'b0;
    logic PRESET = 1'b1;

    uart_rx_fifo_if #(.DEPTH(DEPTH), .DATA_W(8)) bus ();

    uart_rx_fifo #(.DEPTH(DEPTH), .DATA_W(8)) dut (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .bus    (bus)
    );

    always #5 PCLK = ~PCLK;

    int        total = 0;
    int        bad   = 0;
    rx_entry_t exp_q[$];
    int        occ      = 0;
    bit        exp_ovr  = 0;
    bit        exp_trig = 0;
    bit        exp_tmo  = 0;
    int        idle     = 0;
    logic [1:0] lvl_sel = 2'b11;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lvlOf(input logic [1:0] s);
        case (s)
            2'b00:   return 1;
            2'b01:   return 4;
            2'b10:   return 8;
            default: return 14;
        endcase
    endfunction

    // Read monitor: whenever a pop is presented, the head must match the model.
    always @(negedge PCLK) begin
        rx_entry_t e;
        if (!PRESET && bus.i_rd_en) begin
            if (occ > 0 && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput("rd_data", 32'(bus.o_rd_data), 32'(e.data));
                checkOutput("rd_flags", {29'd0, bus.o_break, bus.o_framing_err, bus.o_parity_err},
                            {29'd0, e.brk, e.ferr, e.perr});
            end else begin
                checkOutput("rd_empty_data", 32'(bus.o_rd_data), 32'd0);
            end
        end
    end

    task automatic checkAll();
        bit any_err;
        any_err = 0;
        foreach (exp_q[i]) if (exp_q[i].perr || exp_q[i].ferr || exp_q[i].brk) any_err = 1;
        checkOutput("count", 32'(bus.o_count), 32'(occ));
        checkOutput("data_ready", 32'(bus.o_data_ready), 32'(occ > 0));
        checkOutput("overrun", 32'(bus.o_overrun), 32'(exp_ovr));
        checkOutput("fifo_err", 32'(bus.o_fifo_err), 32'(any_err));
        checkOutput("trig", 32'(bus.o_trig), 32'(exp_trig));
        checkOutput("RXDRDYn", 32'(bus.RXDRDYn), 32'(!(exp_trig || exp_tmo)));
`ifdef UART_RX_TIMEOUT_EN
        checkOutput("timeout", 32'(bus.o_timeout), 32'(exp_tmo));
`endif
        if (occ > 0 && exp_q.size() > 0) begin
            checkOutput("head_data", 32'(bus.o_rd_data), 32'(exp_q[0].data));
            checkOutput("head_perr", 32'(bus.o_parity_err), 32'(exp_q[0].perr));
        end else begin
            checkOutput("head_zero", {21'd0, bus.o_break, bus.o_framing_err, bus.o_parity_err, bus.o_rd_data}, 32'd0);
        end
    endtask

    // One clock of stimulus; the model is advanced from the rules after the edge.
    task automatic applyStimulus(input logic v, input logic [7:0] d, input logic p, input logic f,
                                 input logic b, input logic rd, input logic lsr, input logic clr,
                                 input logic tick);
        int        occ_pre;
        bit        accept;
        bit        popped;
        rx_entry_t e;
        bus.i_rx_valid = v;
        bus.i_rx_data  = d;
        bus.i_rx_perr  = p;
        bus.i_rx_ferr  = f;
        bus.i_rx_brk   = b;
        bus.i_rd_en    = rd;
        bus.i_lsr_rd   = lsr;
        bus.i_clr      = clr;
        bus.i_trig_lvl = lvl_sel;
`ifdef UART_RX_TIMEOUT_EN
        bus.i_char_tick = tick;
`endif
        occ_pre = occ;
        accept  = v && !clr && (occ_pre < DEPTH || (rd && occ_pre > 0));
        if (accept) begin
            e.data = d; e.perr = p; e.ferr = f; e.brk = b;
            exp_q.push_back(e);
        end
        @(posedge PCLK);
        #1;
        popped = rd && occ_pre > 0;
        if (v && occ_pre == DEPTH && !rd) exp_ovr = 1;
        else if (lsr)                     exp_ovr = 0;
        exp_trig = (occ_pre >= lvlOf(lvl_sel));
`ifdef UART_RX_TIMEOUT_EN
        if (v || rd || clr || occ_pre == 0) begin
            idle = 0; exp_tmo = 0;
        end else if (tick) begin
            idle++;
            if (idle >= RX_TIMEOUT_CHARS) exp_tmo = 1;
        end
`else
        if (tick) idle = 0;
`endif
        if (clr) begin
            exp_q.delete();
            occ = 0;
        end else begin
            occ = occ_pre + int'(accept) - int'(popped);
        end
        checkAll();
    endtask

    task automatic pushChar(input logic [7:0] d, input logic p = 0);
        applyStimulus(1, d, p, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic popChar();
        applyStimulus(0, 8'h00, 0, 0, 0, 1, 0, 0, 0);
    endtask

    task automatic idleCycle();
        applyStimulus(0, 8'h00, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic drain();
        while (occ > 0) popChar();
    endtask

    initial begin
        bus.i_rx_valid = 0; bus.i_rx_data = 0; bus.i_rx_perr = 0; bus.i_rx_ferr = 0;
        bus.i_rx_brk = 0; bus.i_rd_en = 0; bus.i_lsr_rd = 0; bus.i_clr = 0;
        bus.i_trig_lvl = lvl_sel;
`ifdef UART_RX_TIMEOUT_EN
        bus.i_char_tick = 0;
`endif
        #23;
        checkAll();
        PRESET = 0;
        @(posedge PCLK);
        #1;

        $display("[TB] basic push/pop");
        pushChar(8'h41); pushChar(8'h42); pushChar(8'h43);
        popChar(); popChar(); popChar();
        idleCycle();

        $display("[TB] trigger level 4");
        lvl_sel = 2'b01;
        for (int i = 0; i < 4; i++) pushChar(8'(8'h50 + i));
        idleCycle(); idleCycle();
        popChar(); idleCycle();
        drain(); idleCycle();

        $display("[TB] overrun");
        for (int i = 0; i < DEPTH; i++) pushChar(8'(i));
        pushChar(8'hAA);
        idleCycle();
        applyStimulus(0, 8'h00, 0, 0, 0, 0, 1, 0, 0);
        applyStimulus(1, 8'hBB, 0, 0, 0, 1, 0, 0, 0);
        drain(); idleCycle();

        $display("[TB] error flags");
        pushChar(8'h10, 1); pushChar(8'h20);
        popChar(); popChar(); idleCycle();

        $display("[TB] flush");
        for (int i = 0; i < DEPTH; i++) pushChar(8'(8'h80 + i));
        pushChar(8'hCC);
        applyStimulus(1, 8'h77, 0, 1, 0, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++) pushChar(8'(8'h60 + i), 1);
        applyStimulus(1, 8'h99, 0, 0, 0, 0, 0, 1, 0);
        applyStimulus(0, 8'h00, 0, 0, 0, 0, 1, 0, 0);

        $display("[TB] asynchronous reset");
        lvl_sel = 2'b00;
        pushChar(8'h31); pushChar(8'h32, 1); idleCycle();
        bus.i_rx_valid = 0; bus.i_rd_en = 0;
        #2;
        PRESET = 1;
        #1;
        exp_q.delete(); occ = 0; exp_ovr = 0; exp_trig = 0; exp_tmo = 0; idle = 0;
        checkAll();
        @(posedge PCLK);
        #1;
        PRESET = 0;
        idleCycle();

`ifdef UART_RX_TIMEOUT_EN
        $display("[TB] receive timeout");
        lvl_sel = 2'b11;
        pushChar(8'h5A);
        for (int i = 0; i < RX_TIMEOUT_CHARS; i++) begin
            applyStimulus(0, 8'h00, 0, 0, 0, 0, 0, 0, 1);
            idleCycle();
        end
        popChar(); idleCycle();
`endif

        $display("[TB] random traffic");
        for (int seg = 0; seg < 12; seg++) begin
            int pv, pr;
            lvl_sel = 2'($urandom_range(3));
            pv = $urandom_range(20, 90);
            pr = $urandom_range(20, 90);
            for (int c = 0; c < 150; c++) begin
                applyStimulus($urandom_range(99) < pv, 8'($urandom),
                              $urandom_range(7) == 0, $urandom_range(7) == 0,
                              $urandom_range(15) == 0, $urandom_range(99) < pr,
                              $urandom_range(7) == 0, $urandom_range(63) == 0,
                              $urandom_range(2) == 0);
            end
        end
        drain(); idleCycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive buffer between `uart_rx` (producer) and the APB register file / glue logic (consumer).
- Stores each received character together with its per-character error flags.
- Generates the LSR receive-status bits and the receive-trigger level.
- Drives the DMA request `RXDRDYn`.
- Runs entirely in the `PCLK` domain; `rx_valid` is delivered already synchronised as a one-cycle `PCLK` pulse.

Parameters:
- DEPTH, 16, number of entries; power of two, at least 16.
- DATA_W, 8, character width.
- PTR_W, $clog2(DEPTH), pointer width (derived; do not override).

Ports:
- PCLK  in  1  system clock
- PRESET  in  1  asynchronous active-high reset
- i_rx_data  in  DATA_W  received character
- i_rx_perr  in  1  parity error for this character
- i_rx_ferr  in  1  framing error for this character
- i_rx_brk  in  1  break detected for this character
- i_rx_valid  in  1  push strobe, one cycle
- i_rd_en  in  1  pop strobe (APB read of RBR), one cycle
- i_lsr_rd  in  1  APB read of LSR (clears sticky bits)
- i_clr  in  1  synchronous flush (FCR RX reset)
- i_trig_lvl  in  2  trigger select: 00=1, 01=4, 10=8, 11=14 entries
- o_rd_data  out  DATA_W  head character (first-word-fall-through)
- o_data_ready  out  1  LSR[0]: FIFO not empty
- o_overrun  out  1  LSR[1]: sticky overrun
- o_parity_err  out  1  LSR[2]: head entry parity flag
- o_framing_err  out  1  LSR[3]: head entry framing flag
- o_break  out  1  LSR[4]: head entry break flag
- o_fifo_err  out  1  LSR[7]: at least one stored entry carries an error
- o_count  out  PTR_W+1  occupancy
- o_trig  out  1  occupancy at or above the trigger level
- RXDRDYn  out  1  DMA request, active low

Behaviour:
- Reset:
  - Pointers, count and error counter are 0.
  - `o_overrun` = 0 and `o_data_ready` = 0.
  - `o_rd_data` and the head flags are 0.
  - `o_trig` = 0 and `RXDRDYn` = 1.
- Push (`i_rx_valid`, not full): write {brk, ferr, perr, data} at the write pointer; wptr+1 modulo DEPTH; count+1. The entry is visible on the head outputs the next cycle if the FIFO was empty.
- Pop (`i_rd_en`, not empty): rptr+1 modulo DEPTH; count-1. Head outputs show the next entry the following cycle. Pop while empty is ignored.
- Head outputs (`o_rd_data`, `o_parity_err`, `o_framing_err`, `o_break`) are forced to 0 when the FIFO is empty.
- Push while full and no simultaneous pop:
  - The character is dropped and the FIFO contents are unchanged.
  - `o_overrun` is set on the next edge.
- Push and pop in the same cycle:
  - When full, both occur, count is unchanged and there is no overrun.
  - When empty, only the push takes effect.
- `o_overrun` clears on `i_lsr_rd`. If an overrun push coincides with `i_lsr_rd`, set wins.
- Error counter (PTR_W+1 bits):
  - +1 on push of an entry with any flag set.
  - -1 on pop of a head entry with any flag set.
  - Both in the same cycle: unchanged.
  - `o_fifo_err` = (counter != 0).
- `i_clr`:
  - Zeroes pointers, count and the error counter on the next edge, with priority over a push/pop in the same cycle.
  - `o_overrun` is not cleared.
- `o_trig` and `RXDRDYn`:
  - Registered: `o_trig` = (count >= level) one cycle after count changes; `RXDRDYn` = ~`o_trig`.
  - With level 1, `RXDRDYn` falls one cycle after the first push.
  - Level 14 with DEPTH 16 is exact; for DEPTH > 16 the levels are unchanged.
- Wrap-around: full = (count == DEPTH). Pointers wrap naturally at DEPTH.

Optional Feature:
- Macro: UART_RX_TIMEOUT_EN.
- When defined:
  - Adds input `i_char_tick` (one `PCLK` pulse per character time, from baud_gen) and output `o_timeout`.
  - A 2-bit idle counter increments on `i_char_tick` while count>0 and there is no push/pop that cycle.
  - It resets on any push, pop or `i_clr`, or while empty.
  - On reaching 4 ticks, `o_timeout` = 1 and stays until the next pop, push or `i_clr`.
  - In this mode `RXDRDYn` = ~(`o_trig` | `o_timeout`).
- When undefined: no port, no counter, and `RXDRDYn` = ~`o_trig`.

Decomposition:
- Package `uart_pkg` holds:
  - typedef `rx_entry_t` packed struct {brk, ferr, perr, data[7:0]};
  - enum `rx_trig_e` {TRIG_1, TRIG_4, TRIG_8, TRIG_14};
  - function `trig_level(rx_trig_e)` returning the threshold;
  - localparam `RX_TIMEOUT_CHARS` = 4.
- One sub-module, `uart_fifo_core`: a generic register-array FIFO parameterised by element type and DEPTH, with push/pop/clr, count, and full/empty.
- The top layer adds overrun, the error counter, trigger, DMA and timeout logic.

Test Plan:
- Reset then 3 pushes of 0x41, 0x42, 0x43 -> `o_count`=3, `o_rd_data`=0x41, `o_data_ready`=1. Three pops return 0x41, 0x42, 0x43, then `o_data_ready`=0 and `o_rd_data`=0.
- `i_trig_lvl`=01, 4 pushes -> `RXDRDYn` stays 1 after push 3 and goes 0 one cycle after the count reaches 4. One pop -> `RXDRDYn` returns to 1.
- 16 pushes then a 17th push of 0xAA -> `o_overrun`=1 and `o_count`=16; draining shows 0xAA never appears. `i_lsr_rd` -> `o_overrun`=0. Repeat with push+pop in the same cycle when full -> no overrun, count stays 16.
- Push 0x10 (perr=1), then 0x20 clean -> `o_fifo_err`=1 and `o_parity_err`=1 at the head. Pop -> `o_parity_err`=0 and `o_fifo_err`=0.
- 5 pushes, `i_clr` in the same cycle as a push -> `o_count`=0, `o_fifo_err`=0, overrun unaffected. Assert PRESET mid-sequence -> all outputs return to their reset values asynchronously.
- (UART_RX_TIMEOUT_EN) 1 push, then 4 `i_char_tick` with no activity -> `o_timeout`=1 and `RXDRDYn`=0 with `i_trig_lvl`=11. A pop clears `o_timeout`.
